// File: rtl/dice_pool_roller.sv
// Rolls 1..MAX_DICE dice of SIDES faces from a raw random stream (rejection sampling),
// with sum/advantage/disadvantage, saturating modifier and target compare. Critical-roll
// override of hit and the natural flags are enabled by defining DICE_CRIT_EN.
module dice_pool_roller #(
    parameter int NUM_BITS  = 8,
    parameter int SIDES     = 20,
    parameter int MAX_DICE  = 4,
    localparam int RAND_BITS = $clog2(SIDES),
    localparam int CNT_BITS  = $clog2(MAX_DICE + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       next,
    input  logic [CNT_BITS-1:0]        count,
    input  logic [1:0]                 mode,
    input  logic signed [NUM_BITS-1:0] mod,
    input  logic signed [NUM_BITS-1:0] target,
    input  logic                       rand_valid,
    input  logic [RAND_BITS-1:0]       rand_data,
    output logic                       rand_ready,
    output logic                       busy,
    output logic                       done,
    output logic signed [NUM_BITS-1:0] final_num,
    output logic                       hit,
    output logic                       nat_max,
    output logic                       nat_min
);

    localparam int DIE_BITS = $clog2(SIDES + 1);
    localparam int SUM_BITS = $clog2(MAX_DICE * SIDES + 1);
    localparam int EXT_BITS = ((SUM_BITS > NUM_BITS) ? SUM_BITS : NUM_BITS) + 2;
    localparam int DL_BITS  = (CNT_BITS > 2) ? CNT_BITS : 2;

    localparam logic [RAND_BITS:0] SIDES_W = (RAND_BITS + 1)'(SIDES);
    localparam logic signed [EXT_BITS-1:0] SAT_MAX =
        {{(EXT_BITS - NUM_BITS + 1){1'b0}}, {(NUM_BITS - 1){1'b1}}};
    localparam logic signed [EXT_BITS-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_ROLL, S_RESOLVE} state_t;
    typedef enum logic [1:0] {M_SUM, M_ADV, M_DIS} roll_mode_t;

    state_t                      state_q;
    roll_mode_t                  mode_q;
    logic [DL_BITS-1:0]          dice_left_q;
    logic [SUM_BITS-1:0]         acc_q;
    logic signed [NUM_BITS-1:0]  mod_q;
    logic signed [NUM_BITS-1:0]  target_q;
    logic                        rand_ready_q;
    logic                        busy_q;
    logic                        done_q;
    logic signed [NUM_BITS-1:0]  final_num_q;
    logic                        hit_q;
    logic                        nat_max_q;
    logic                        nat_min_q;
`ifdef DICE_CRIT_EN
    logic                        single_q;
`endif

    roll_mode_t                  mode_sel;
    logic [DL_BITS-1:0]          dice_req;
    logic                        accept;
    logic [DIE_BITS-1:0]         die;
    logic [SUM_BITS-1:0]         die_ext;
    logic [SUM_BITS-1:0]         acc_d;
    logic signed [EXT_BITS-1:0]  roll_ext;
    logic signed [EXT_BITS-1:0]  mod_ext;
    logic signed [EXT_BITS-1:0]  total;
    logic signed [NUM_BITS-1:0]  final_d;
    logic                        hit_cmp;
    logic                        hit_d;
    logic                        nat_max_d;
    logic                        nat_min_d;

    // Request decode: adv/dis always roll a pair; sum clamps count into 1..MAX_DICE.
    always_comb begin
        mode_sel = M_SUM;
        dice_req = DL_BITS'(2);
        if (mode == 2'b01) begin
            mode_sel = M_ADV;
        end else if (mode == 2'b10) begin
            mode_sel = M_DIS;
        end else if (count == '0) begin
            dice_req = DL_BITS'(1);
        end else if (count > CNT_BITS'(MAX_DICE)) begin
            dice_req = DL_BITS'(MAX_DICE);
        end else begin
            dice_req = DL_BITS'(count);
        end
    end

    assign accept  = rand_valid && rand_ready_q && ({1'b0, rand_data} < SIDES_W);
    assign die     = DIE_BITS'(rand_data) + DIE_BITS'(1);
    assign die_ext = SUM_BITS'(die);

    // Disadvantage uses the cleared accumulator (0) as "no die yet", since dice are >= 1.
    always_comb begin
        acc_d = acc_q;
        case (mode_q)
            M_ADV:   acc_d = (die_ext > acc_q) ? die_ext : acc_q;
            M_DIS:   acc_d = ((acc_q == '0) || (die_ext < acc_q)) ? die_ext : acc_q;
            default: acc_d = acc_q + die_ext;
        endcase
    end

    assign roll_ext = {{(EXT_BITS - SUM_BITS){1'b0}}, acc_q};
    assign mod_ext  = {{(EXT_BITS - NUM_BITS){mod_q[NUM_BITS-1]}}, mod_q};
    assign total    = roll_ext + mod_ext;

    always_comb begin
        final_d = total[NUM_BITS-1:0];
        if (total > SAT_MAX) begin
            final_d = SAT_MAX[NUM_BITS-1:0];
        end else if (total < SAT_MIN) begin
            final_d = SAT_MIN[NUM_BITS-1:0];
        end
    end

    assign hit_cmp = (final_d >= target_q);

`ifdef DICE_CRIT_EN
    logic flag_en;
    assign flag_en   = (mode_q != M_SUM) || single_q;
    assign nat_max_d = flag_en && (acc_q == SUM_BITS'(SIDES));
    assign nat_min_d = flag_en && (acc_q == SUM_BITS'(1));
    assign hit_d     = nat_max_d ? 1'b1 : (nat_min_d ? 1'b0 : hit_cmp);
`else
    assign nat_max_d = 1'b0;
    assign nat_min_d = 1'b0;
    assign hit_d     = hit_cmp;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            mode_q       <= M_SUM;
            dice_left_q  <= '0;
            acc_q        <= '0;
            mod_q        <= '0;
            target_q     <= '0;
            rand_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            final_num_q  <= '0;
            hit_q        <= 1'b0;
            nat_max_q    <= 1'b0;
            nat_min_q    <= 1'b0;
`ifdef DICE_CRIT_EN
            single_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (next) begin
                        state_q      <= S_ROLL;
                        busy_q       <= 1'b1;
                        rand_ready_q <= 1'b1;
                        mode_q       <= mode_sel;
                        dice_left_q  <= dice_req;
                        acc_q        <= '0;
                        mod_q        <= mod;
                        target_q     <= target;
`ifdef DICE_CRIT_EN
                        single_q     <= (dice_req == DL_BITS'(1));
`endif
                    end
                end
                S_ROLL: begin
                    if (accept) begin
                        acc_q       <= acc_d;
                        dice_left_q <= dice_left_q - DL_BITS'(1);
                        if (dice_left_q == DL_BITS'(1)) begin
                            rand_ready_q <= 1'b0;
                            state_q      <= S_RESOLVE;
                        end
                    end
                end
                S_RESOLVE: begin
                    final_num_q <= final_d;
                    hit_q       <= hit_d;
                    nat_max_q   <= nat_max_d;
                    nat_min_q   <= nat_min_d;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rand_ready = rand_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign final_num  = final_num_q;
    assign hit        = hit_q;
    assign nat_max    = nat_max_q;
    assign nat_min    = nat_min_q;

endmodule

// File: doc/dice_pool_roller.md
# dice_pool_roller

Parametrised successor to the single-d20 roller: rolls 1..MAX_DICE dice of SIDES faces from an external raw random stream using rejection sampling. It supports sum, advantage and disadvantage modes, applies a signed modifier with saturation, and compares the result against a signed target. It sits between the random-bit source (memory or generator) and the game-logic/display side, replacing the old roller in `top`.

## Interface
- NUM_BITS, 8, signed width of mod, target, final_num
- SIDES, 20, faces per die (2..256)
- MAX_DICE, 4, max dice per normal-mode roll (1..15)
- RAND_BITS (localparam), $clog2(SIDES), raw sample width
- CNT_BITS (localparam), $clog2(MAX_DICE+1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (one clock domain)
- next  in  1  start request, sampled in IDLE
- count  in  CNT_BITS  dice to roll in normal mode
- mode  in  2  00 sum, 01 advantage, 10 disadvantage, 11 treated as 00
- mod  in  NUM_BITS  signed modifier
- target  in  NUM_BITS  signed target
- rand_valid  in  1  raw sample valid
- rand_data  in  RAND_BITS  raw sample
- rand_ready  out  1  block accepts a sample this cycle
- busy  out  1  roll in progress
- done  out  1  one-cycle result strobe
- final_num  out  NUM_BITS  signed saturated result
- hit  out  1  result meets target
- nat_max  out  1  kept die is SIDES
- nat_min  out  1  kept die is 1

## Operation
- FSM: IDLE -> ROLL -> RESOLVE -> IDLE.
- IDLE: next=1 latches count, mode, mod, target; clears the accumulator; goes to ROLL. Inputs are ignored after the latch.
- Latched count: 0 is treated as 1; values above MAX_DICE clamp to MAX_DICE. Advantage and disadvantage always roll exactly 2 dice.
- ROLL: rand_ready=1. A transfer occurs on rand_valid & rand_ready.
  - rand_data >= SIDES: sample is rejected. No die is consumed; wait for the next sample.
  - Otherwise: die = rand_data+1. Sum mode adds it; advantage keeps the max; disadvantage keeps the min (first die initialises). dice_left decrements.
  - The last accepted die moves the FSM to RESOLVE.
- RESOLVE: compute roll+mod at full width, saturated to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1].
  - hit = (final_num >= target), signed compare.
  - Natural flags apply to the kept die in adv/dis mode, or in sum mode only when count==1. Otherwise both flags are 0.
- next during ROLL/RESOLVE is ignored. No queueing.
- Reset values: rand_ready=0, busy=0, done=0, final_num=0, hit=0, nat_max=0, nat_min=0, state IDLE.
- Reset mid-roll aborts immediately. Partial results are discarded and done does not assert.

## Timing
- Edge E0 samples next=1. busy=1 and rand_ready=1 from E0.
- With no stalls or rejections, the dice transfer on E1..Ek; k=count in sum mode, k=2 in adv/dis.
- At Ek, rand_ready falls and the FSM enters RESOLVE.
- At Ek+1: final_num, hit and flags are registered; done=1 for exactly one cycle; busy=0.
- Latency is k+1 edges after E0 minimum. Each rejected sample or rand_valid gap adds one cycle.
- Outputs hold their values until the next done. A new next is accepted on the first edge after busy falls.

## Configuration
- DICE_CRIT_EN defined:
  - nat_max forces hit=1 and nat_min forces hit=0, regardless of the comparison.
  - Flags are driven as specified above.
- Undefined:
  - hit is the pure comparison.
  - nat_max and nat_min are tied to 0.

## Test plan
- Sum mode, count=1, mod=5, target=10, rand 9 -> die 10, final_num=15, hit=1, flags 0. done is one cycle after the transfer edge (E2).
- Rejection: count=1, rand 25, 31, 20, 19, mod=-30, target=0 -> three rejects, die 20, final_num=-10, nat_max=1. hit=1 with DICE_CRIT_EN, hit=0 without. done is 3 cycles later than in the first scenario.
- Adv/dis, mod=7, target=-5:
  - Advantage, rand 2, 17 -> kept 18, final_num=25, hit=1.
  - Disadvantage, rand 0, 17 -> kept 1, final_num=8, nat_min=1. hit=0 with DICE_CRIT_EN, hit=1 without.
- Saturation/clamp: count=7 (clamped to 4), rand 19 x4, mod=100 -> roll 80, final_num=127. Same roll with mod=-128 and rand 0 x4 -> final_num=-124.
- Flow control: rand_valid toggles 1,0,0,1,1 during count=3 -> exactly 3 dice consumed; rand_ready low outside ROLL. next pulsed mid-roll has no effect.
- Reset: assert reset after 2 of 3 dice -> all outputs 0 immediately, no done. A following roll (count=1, rand 4) gives final_num=5+mod.
